// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter and its watchdog.
package wb_arbiter2_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned SEL_WIDTH      = 4;
  localparam int unsigned STATE_WIDTH    = 2;

  // Arbiter states
  localparam logic [STATE_WIDTH-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_GNT0 = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_GNT1 = 2'd2;

  // Address-independent part of a master request
  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat_w;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  we;
  } wb_wpayload_t;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter
  function automatic int unsigned wdog_cnt_width(input int unsigned timeout);
    if (timeout == 0) return 1;
    return 32'($clog2(timeout + 1));
  endfunction

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles and fires a
// one-cycle pulse on the TIMEOUT-th one. TIMEOUT=0 disables it.
module wb_watchdog
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic fire
);

  localparam int unsigned        CW       = wdog_cnt_width(TIMEOUT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]      CNT_MAX  = {CW{1'b1}};
  localparam logic               ENABLE   = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;
  logic          w_fire;

  // Fire on the last stalled cycle; >= keeps the compare safe if the count ever overshoots
  assign w_fire = ENABLE & stall & (r_cnt >= CNT_LAST);
  assign fire   = w_fire;

  // Stall counter: clears on any non-stalled cycle, on clr, and after firing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr | !stall | w_fire) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter. Round-robin between
// m0 (CPU) and m1 (loader/debug); the owner keeps the grant while cyc is
// high, and a watchdog converts a stalled slave into an err to the owner.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0__addr,
  input  logic [DATA_WIDTH-1:0] m0__dat_w,
  input  logic [SEL_WIDTH-1:0]  m0__sel,
  input  logic                  m0__we,
  input  logic                  m0__cyc,
  input  logic                  m0__stb,
  output logic [DATA_WIDTH-1:0] m0__dat_r,
  output logic                  m0__ack,
  output logic                  m0__err,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1__addr,
  input  logic [DATA_WIDTH-1:0] m1__dat_w,
  input  logic [SEL_WIDTH-1:0]  m1__sel,
  input  logic                  m1__we,
  input  logic                  m1__cyc,
  input  logic                  m1__stb,
  output logic [DATA_WIDTH-1:0] m1__dat_r,
  output logic                  m1__ack,
  output logic                  m1__err,
  // slave
  output logic [ADDR_WIDTH-1:0] s__addr,
  output logic [DATA_WIDTH-1:0] s__dat_w,
  output logic [SEL_WIDTH-1:0]  s__sel,
  output logic                  s__we,
  output logic                  s__cyc,
  output logic                  s__stb,
  input  logic [DATA_WIDTH-1:0] s__dat_r,
  input  logic                  s__ack,
  input  logic                  s__err
);

  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_state_nxt;
  logic                   r_last;
  logic                   w_last_nxt;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_stall;
  logic                   w_fire;
  wb_wpayload_t           w_m0_pl;
  wb_wpayload_t           w_m1_pl;
  wb_wpayload_t           w_s_pl;

  // State and round-robin pointer; last=1 lets m0 win the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: grant from IDLE only, release to IDLE when the owner drops cyc
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0__cyc & m1__cyc) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (m0__cyc) begin
          w_state_nxt = ST_GNT0;
        end else if (m1__cyc) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0__cyc) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!m1__cyc) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_gnt0  = (r_state == ST_GNT0);
  assign w_gnt1  = (r_state == ST_GNT1);
  assign w_m0_pl = '{dat_w: m0__dat_w, sel: m0__sel, we: m0__we};
  assign w_m1_pl = '{dat_w: m1__dat_w, sel: m1__sel, we: m1__we};

  // Slave-side mux: everything driven to zero unless a master owns the bus
  always_comb begin
    s__addr = '0;
    w_s_pl  = '0;
    s__cyc  = 1'b0;
    s__stb  = 1'b0;
    if (w_gnt0) begin
      s__addr = m0__addr;
      w_s_pl  = w_m0_pl;
      s__cyc  = m0__cyc;
      s__stb  = m0__stb & m0__cyc;
    end else if (w_gnt1) begin
      s__addr = m1__addr;
      w_s_pl  = w_m1_pl;
      s__cyc  = m1__cyc;
      s__stb  = m1__stb & m1__cyc;
    end
  end

  assign s__dat_w = w_s_pl.dat_w;
  assign s__sel   = w_s_pl.sel;
  assign s__we    = w_s_pl.we;

  // A strobe the slave neither acks nor errors; excluding ack makes ack win over a timeout
  assign w_stall = (w_gnt0 | w_gnt1) & s__stb & !s__ack & !s__err;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (r_state == ST_IDLE),
    .stall (w_stall),
    .fire  (w_fire)
  );

  // Master-side responses go only to the current owner
  assign m0__dat_r = s__dat_r;
  assign m1__dat_r = s__dat_r;
  assign m0__ack   = w_gnt0 & s__ack;
  assign m1__ack   = w_gnt1 & s__ack;
  assign m0__err   = w_gnt0 & (s__err | w_fire);
  assign m1__err   = w_gnt1 & (s__err | w_fire);

endmodule
